som_dec_2x4_pope_behav: RTL and testbench

// - Evaluates F = A(CD + B) + BC' using a 2x4 positive-output, positive-enable decoder.
//   A and B drive the decoder selects; C and D drive the data-side gating.
// - Leaf logic block. The result and the raw decoder lines are registered once on clk.
// - E gates the whole function. When E=0, F=0 regardless of A..D.
//

---
 rtl/som_dec_2x4_pope_behav_pkg.sv | 20 ++
 rtl/som_dec_2x4_pope_behav_dec.sv | 26 ++
 rtl/som_dec_2x4_pope_behav.sv | 43 ++++
 tb/tb_som_dec_2x4_pope_behav.sv | 134 +++++++++++++
 4 files changed

// File: rtl/som_dec_2x4_pope_behav_pkg.sv
// Shared types and helpers for the decoder-based SOP block.
// Decoder width and the sum-of-products over the decoder lines.
package som_dec_2x4_pope_behav_pkg;

  localparam int unsigned DEC_W = 4;

  typedef logic [DEC_W-1:0] dec_t;

  // F = Y1.C' + Y2.C.D + Y3
  function automatic logic dec_sop(
    input dec_t y,
    input logic c,
    input logic d
  );
    return (y[1] & ~c)
         | (y[2] & c & d)
         | y[3];
  endfunction

endpackage

// File: rtl/som_dec_2x4_pope_behav_dec.sv
// 2x4 decoder, positive outputs, positive enable.
// Purely combinational; one-hot on {s1,s0} when en=1.
module dec_2x4_pope
  import som_dec_2x4_pope_behav_pkg::*;
(
  input  logic s1,
  input  logic s0,
  input  logic en,
  output dec_t y
);

  // One line per select code, all low when disabled
  always_comb begin
    y = '0;
    if (en) begin
      unique case ({s1, s0})
        2'd0: y = 4'b0001;
        2'd1: y = 4'b0010;
        2'd2: y = 4'b0100;
        2'd3: y = 4'b1000;
        default: y = '0;
      endcase
    end
  end

endmodule

// File: rtl/som_dec_2x4_pope_behav.sv
// F = A(CD + B) + BC' built on a 2x4 decoder.
// F and the raw decoder lines are registered once.
module som_dec_2x4_pope_behav
  import som_dec_2x4_pope_behav_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic       F,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  input  logic       E,
  output logic [3:0] dec_y
);

  dec_t y;
  logic f_next;

  dec_2x4_pope u_dec (
    .s1 (A),
    .s0 (B),
    .en (E),
    .y  (y)
  );

  // Sum of products over the decoder lines
  always_comb begin
    f_next = dec_sop(y, C, D);
  end

  // Output registers, synchronous reset has priority
  always_ff @(posedge clk) begin
    if (rst) begin
      F     <= 1'b0;
      dec_y <= '0;
    end else begin
      F     <= f_next;
      dec_y <= y;
    end
  end

endmodule

// File: tb/tb_som_dec_2x4_pope_behav.sv
// Directed bench for som_dec_2x4_pope_behav.
// Expected values come from F_ONSET and one-hot select codes.
module tb_som_dec_2x4_pope_behav;

  localparam logic [15:0] F_ONSET = 16'hF830;

  logic       clk = 1'b0;
  logic       rst;
  logic       F;
  logic       A, B, C, D, E;
  logic [3:0] dec_y;

  int n_chk = 0;
  int n_err = 0;

  som_dec_2x4_pope_behav dut (
    .clk   (clk),
    .rst   (rst),
    .F     (F),
    .A     (A),
    .B     (B),
    .C     (C),
    .D     (D),
    .E     (E),
    .dec_y (dec_y)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [3:0] obs,
    input logic [3:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, want %b", tag, obs, exp);
    end
  endtask

  // drive at negedge, clock once, settle past the edge
  task automatic step(
    input logic       r,
    input logic [3:0] code,
    input logic       e
  );
    @(negedge clk);
    rst = r;
    {A, B, C, D} = code;
    E = e;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] onehot(input logic [3:0] code);
    logic [1:0] s;
    s = code[3:2];
    return 4'b0001 << s;
  endfunction

  logic [15:0] onset;
  logic [3:0]  code;

  initial begin
    onset = F_ONSET;
    rst = 1'b1;
    {A, B, C, D, E} = 5'b11111;

    // reset with all inputs high
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 4'b1111, 1'b1);
      chk("rst_F", {3'b0, F}, 4'b0000);
      chk("rst_dec", dec_y, 4'b0000);
    end
    step(1'b0, 4'b1111, 1'b1);
    chk("rel_F", {3'b0, F}, 4'b0001);
    chk("rel_dec", dec_y, 4'b1000);

    // enable off sweep plus wrap
    for (int i = 0; i < 17; i++) begin
      code = 4'(i);
      step(1'b0, code, 1'b0);
      chk($sformatf("e0_F_%0d", i), {3'b0, F}, 4'b0000);
      chk($sformatf("e0_dec_%0d", i), dec_y, 4'b0000);
    end

    // enable on sweep
    for (int i = 0; i < 16; i++) begin
      code = 4'(i);
      step(1'b0, code, 1'b1);
      chk($sformatf("e1_F_%0d", i), {3'b0, F}, {3'b0, onset[i]});
      chk($sformatf("e1_dec_%0d", i), dec_y, onehot(code));
    end

    // spot values
    step(1'b0, 4'b0100, 1'b1);
    chk("sp_0100", {3'b0, F}, 4'b0001);
    step(1'b0, 4'b0110, 1'b1);
    chk("sp_0110", {3'b0, F}, 4'b0000);
    step(1'b0, 4'b1010, 1'b1);
    chk("sp_1010", {3'b0, F}, 4'b0000);
    chk("sp_1010_dec", dec_y, 4'b0100);
    step(1'b0, 4'b1011, 1'b1);
    chk("sp_1011", {3'b0, F}, 4'b0001);
    step(1'b0, 4'b1100, 1'b1);
    chk("sp_1100", {3'b0, F}, 4'b0001);

    // mid-sweep reset
    step(1'b1, 4'b1101, 1'b1);
    chk("mr_F", {3'b0, F}, 4'b0000);
    chk("mr_dec", dec_y, 4'b0000);
    step(1'b0, 4'b1101, 1'b1);
    chk("mr_rel_F", {3'b0, F}, 4'b0001);
    chk("mr_rel_dec", dec_y, 4'b1000);
    step(1'b0, 4'b0010, 1'b1);
    chk("mr_0010", {3'b0, F}, 4'b0000);
    step(1'b0, 4'b0101, 1'b1);
    chk("mr_0101", {3'b0, F}, 4'b0001);
    chk("mr_0101_dec", dec_y, 4'b0010);

    // enable toggle at 1111
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 4'b1111, 1'(i % 2));
      chk($sformatf("tg_F_%0d", i), {3'b0, F}, {3'b0, 1'(i % 2)});
      chk($sformatf("tg_dec_%0d", i), dec_y,
          (i % 2) ? 4'b1000 : 4'b0000);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
